// File: rtl/fetch_unit.sv
// fetch_unit: program counter and IF/ID register with stall, redirect, halt and range fault.
// Optional perf counters: define FETCH_PERF_CNT_EN.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_addr / imem_data instruction memory address (= pc) and combinational word
//   stall, redirect, redirect_pc, resume   pipeline control inputs
//   if_instr, if_pc, if_valid              IF/ID register contents
//   halted, fault                          HALTED state flag, sticky out-of-range flag
//   perf_cycles, perf_fetched              cycle and fetch counters (FETCH_PERF_CNT_EN only)
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [31:0] IMEM_DEPTH  = 32'd270,
  parameter int          INIT_CYCLES = 2,
  parameter logic [4:0]  HALT_OPCODE = 5'b10000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        resume,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_fetched
`endif
);
  localparam logic [1:0] INIT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (state_q == INIT) begin
      cnt_d   = cnt_q + 32'd1;
      valid_d = 1'b0;
      if (cnt_q == 32'(INIT_CYCLES - 1)) state_d = RUN;
    end else if (state_q == RUN) begin
      if (redirect) begin
        pc_d    = redirect_pc;
        valid_d = 1'b0;
      end else if (pc_q >= IMEM_DEPTH) begin
        fault_d = 1'b1;
        valid_d = 1'b0;
        state_d = HALTED;
      end else if (!stall) begin
        instr_d = imem_data;
        if_pc_d = pc_q;
        valid_d = 1'b1;
        // A halt word parks pc on itself so resume steps past it.
        if (imem_data[31:27] == HALT_OPCODE) state_d = HALTED;
        else pc_d = pc_q + PC_STEP;
      end
    end else begin
      valid_d = 1'b0;
      if (resume && !fault_q) begin
        pc_d    = pc_q + PC_STEP;
        state_d = RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      if_pc_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = valid_q;
  assign halted    = state_q == HALTED;
  assign fault     = fault_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cyc_q, fet_q;
  // Only a real fetch sets valid_d while not stalled in RUN.
  logic fetch;
  assign fetch = (state_q == RUN) && !stall && valid_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      fet_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'(state_q != INIT);
      fet_q <= fet_q + 32'(fetch);
    end
  end
  assign perf_cycles  = cyc_q;
  assign perf_fetched = fet_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        stall, redirect, resume;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr, if_pc;
  logic        if_valid, halted, fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_fetched;
`endif
  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'd272) return 32'h0;
    if (a == 32'd24) return 32'h8000_0000;
    return 32'h1000_0000 + a;
  endfunction
  assign imem_data = mem_word(imem_addr);
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_fetched(perf_fetched)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] a);
    sb.push_back({a, mem_word(a)});
  endtask
  // Each fresh capture (valid and not stalled at the edge) consumes one scoreboard entry.
  task automatic tick;
    logic st;
    logic [63:0] e;
    st = stall;
    @(posedge clk);
    #1;
    if (if_valid && !st) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      chk("sb_pc", if_pc, e[63:32]);
      chk("sb_instr", if_instr, e[31:0]);
    end
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; resume = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    #9 rst_n = 1'b1;
    push(0); push(4); push(8);
    tick; chk("init1_valid", 32'(if_valid), 32'd0);
    tick; chk("init2_valid", 32'(if_valid), 32'd0);
    chk("init_addr", imem_addr, 32'd0);
    tick; chk("first_valid", 32'(if_valid), 32'd1);
    chk("addr_track", imem_addr, 32'd4);
    tick;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("stall_ifpc", if_pc, 32'd4);
      chk("stall_instr", if_instr, mem_word(4));
      chk("stall_addr", imem_addr, 32'd8);
      chk("stall_valid", 32'(if_valid), 32'd1);
    end
    stall = 1'b0;
    tick;
    push(12);
    tick;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_cycles6", perf_cycles, 32'd6);
    chk("perf_fetched4", perf_fetched, 32'd4);
`endif
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd24;
    tick;
    chk("redir_valid", 32'(if_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'd24);
    stall = 1'b0; redirect = 1'b0;
    push(24);
    tick;
    chk("halt_word_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_cycles8", perf_cycles, 32'd8);
    chk("perf_fetched5", perf_fetched, 32'd5);
`endif
    for (int i = 0; i < 5; i++) begin
      redirect = (i == 2); redirect_pc = 32'd100; stall = (i == 3);
      tick;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_valid", 32'(if_valid), 32'd0);
      chk("halt_addr", imem_addr, 32'd24);
    end
    redirect = 1'b0; stall = 1'b0; resume = 1'b1;
    tick;
    resume = 1'b0;
    chk("resume_addr", imem_addr, 32'd28);
    chk("resume_halted", 32'(halted), 32'd0);
    push(28);
    tick;
    redirect = 1'b1; redirect_pc = 32'd268;
    tick;
    redirect = 1'b0;
    push(268);
    tick;
    chk("edge_addr", imem_addr, 32'd272);
    chk("edge_fault", 32'(fault), 32'd0);
    tick;
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_valid", 32'(if_valid), 32'd0);
    chk("oor_addr", imem_addr, 32'd272);
    resume = 1'b1;
    tick;
    resume = 1'b0;
    chk("fault_resume_halted", 32'(halted), 32'd1);
    chk("fault_resume_addr", imem_addr, 32'd272);
    rst_n = 1'b0;
    #1;
    chk("async_fault", 32'(fault), 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    #2 rst_n = 1'b1;
    push(0);
    tick; tick; tick;
    redirect = 1'b1; redirect_pc = 32'd300;
    tick;
    redirect = 1'b0;
    tick;
    chk("f300_fault", 32'(fault), 32'd1);
    chk("f300_halted", 32'(halted), 32'd1);
    chk("f300_valid", 32'(if_valid), 32'd0);
    resume = 1'b1;
    tick;
    resume = 1'b0;
    chk("f300_resume", imem_addr, 32'd300);
    rst_n = 1'b0;
    #1;
    chk("f300_rst_fault", 32'(fault), 32'd0);
    chk("f300_rst_addr", imem_addr, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
